// File: rtl/flow_ctrl_pkg.sv
// Shared definitions for the multi-FIFO flow-control FSM:
// the state encoding and the lowest-set-bit encoder used for error_ch.
package flow_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [7:0] lowest_set(input logic [31:0] vec);
        logic [7:0] idx;
        idx = '0;
        for (int unsigned i = 32; i > 0; i--) begin
            if (vec[i-1]) idx = 8'(i - 1);
        end
        return idx;
    endfunction

endpackage

// File: rtl/flow_ctrl_chan.sv
// One output channel: pause hysteresis, saturating stall counter and
// the next registered pause value for this channel.
module flow_ctrl_chan #(
    parameter int unsigned STALL_MAX = 16,
    parameter int unsigned CNT_W     = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic enb,
    input  logic clr,
    input  logic run,
    input  logic hold_all,
    input  logic force_all,
    input  logic almost_full,
    input  logic almost_empty,
    output logic pausa_next,
    output logic stall_hit
);

    logic             hyst_q;
    logic             hyst_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        hyst_d = hyst_q;
        if (clr) begin
            hyst_d = 1'b0;
        end else if (run) begin
            if (almost_full && !almost_empty)
                hyst_d = 1'b1;
            else if (almost_empty && !almost_full)
                hyst_d = 1'b0;
        end

        pausa_next = hold_all | (run & (hyst_d | force_all));

        // Counter tracks the pause value being registered this edge, so it
        // always equals the number of consecutive cycles pausa has been high.
        cnt_d = '0;
        if (!clr && pausa_next)
            cnt_d = (cnt_q == CNT_W'(STALL_MAX)) ? cnt_q : cnt_q + 1'b1;
    end

    assign stall_hit = (STALL_MAX != 0) && (cnt_q == CNT_W'(STALL_MAX));

    always_ff @(posedge clk) begin
        if (!rst) begin
            hyst_q <= 1'b0;
            cnt_q  <= '0;
        end else if (enb) begin
            hyst_q <= hyst_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/flow_ctrl_fsm.sv
// Flow-control FSM: one input FIFO feeding NUM_CH output FIFOs, with pause
// hysteresis, stall timeout, sticky error flags and error channel index.
module flow_ctrl_fsm
    import flow_ctrl_pkg::*;
#(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned CH_W      = 3,
    parameter int unsigned STALL_MAX = 16,
    parameter int unsigned CNT_W     = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enb,
    input  logic              iniciar,
    input  logic [NUM_CH:0]   almost_full,
    input  logic [NUM_CH:0]   full,
    input  logic [NUM_CH:0]   almost_empty,
    input  logic [NUM_CH:0]   empty,
    output logic [NUM_CH-1:0] pausa,
    output logic [NUM_CH-1:0] continuar,
    output logic              error_full,
    output logic              error_timeout,
    output logic [CH_W-1:0]   error_ch,
    output logic              idle,
    output logic [2:0]        state
);

    state_t            state_q;
    state_t            state_d;
    logic [NUM_CH-1:0] pausa_d;
    logic [NUM_CH-1:0] continuar_d;
    logic [NUM_CH-1:0] stall_hit;
    logic              err_full_d;
    logic              err_to_d;
    logic [CH_W-1:0]   err_ch_d;
    logic              idle_d;
    logic              full_hit;
    logic              stall_any;
    logic              clr;
    logic              run;
    logic              hold_all;
    logic              unused;

    assign full_hit  = |full;
    assign stall_any = |stall_hit;
    assign clr       = (state_d == ST_INIT) || (state_d == ST_RESET);
    assign run       = (state_d == ST_ACTIVE);
    assign hold_all  = (state_d == ST_ERROR);
    assign unused    = almost_empty[NUM_CH];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        flow_ctrl_chan #(
            .STALL_MAX(STALL_MAX),
            .CNT_W    (CNT_W)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .enb         (enb),
            .clr         (clr),
            .run         (run),
            .hold_all    (hold_all),
            .force_all   (almost_full[NUM_CH]),
            .almost_full (almost_full[i]),
            .almost_empty(almost_empty[i]),
            .pausa_next  (pausa_d[i]),
            .stall_hit   (stall_hit[i])
        );
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RESET:  state_d = ST_INIT;
            ST_INIT:   if (iniciar) state_d = ST_IDLE;
            ST_IDLE,
            ST_ACTIVE: begin
                if (full_hit || stall_any)
                    state_d = ST_ERROR;
                else if (&empty)
                    state_d = ST_IDLE;
                else
                    state_d = ST_ACTIVE;
            end
            ST_ERROR:  if (iniciar) state_d = ST_INIT;
            default:   state_d = ST_RESET;
        endcase
    end

    // Outputs are computed for the state being entered, then registered.
    always_comb begin
        idle_d      = (state_d == ST_IDLE);
        continuar_d = '0;
        if (state_d == ST_IDLE)
            continuar_d = '1;
        else if (state_d == ST_ACTIVE)
            continuar_d = ~pausa_d;

        err_full_d = 1'b0;
        err_to_d   = 1'b0;
        err_ch_d   = '0;
        if (state_d == ST_ERROR) begin
            if (state_q == ST_ERROR) begin
                err_full_d = error_full;
                err_to_d   = error_timeout;
                err_ch_d   = error_ch;
            end else if (full_hit) begin
                err_full_d = 1'b1;
                err_ch_d   = CH_W'(lowest_set(32'(full)));
            end else begin
                err_to_d   = 1'b1;
                err_ch_d   = CH_W'(lowest_set(32'(stall_hit)));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_RESET;
            pausa         <= '0;
            continuar     <= '0;
            error_full    <= 1'b0;
            error_timeout <= 1'b0;
            error_ch      <= '0;
            idle          <= 1'b0;
        end else if (enb) begin
            state_q       <= state_d;
            pausa         <= pausa_d;
            continuar     <= continuar_d;
            error_full    <= err_full_d;
            error_timeout <= err_to_d;
            error_ch      <= err_ch_d;
            idle          <= idle_d;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_flow_ctrl_fsm.sv
// Bench for flow_ctrl_fsm: two instances (STALL_MAX=16 and STALL_MAX=0) driven
// in lockstep and compared every cycle against a behavioural model.
module tb_flow_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic       enb;
    logic       iniciar;
    logic [4:0] af;
    logic [4:0] fl;
    logic [4:0] ae;
    logic [4:0] em;

    logic [3:0] pausa_o [2];
    logic [3:0] cont_o  [2];
    logic       ef_o    [2];
    logic       et_o    [2];
    logic [2:0] ch_o    [2];
    logic       idle_o  [2];
    logic [2:0] st_o    [2];

    int checks = 0;
    int errors = 0;

    // Model state, index 0 = STALL_MAX 16, index 1 = STALL_MAX 0
    int         smax [2] = '{16, 0};
    int         m_st [2];
    int         m_cnt[2][4];
    bit         m_hy [2][4];
    logic [3:0] m_p  [2];
    logic [3:0] m_c  [2];
    bit         m_ef [2];
    bit         m_et [2];
    int         m_ch [2];
    bit         m_id [2];

    always #5 clk = ~clk;

    flow_ctrl_fsm #(.NUM_CH(4), .CH_W(3), .STALL_MAX(16), .CNT_W(5)) u_a (
        .clk(clk), .rst(rst), .enb(enb), .iniciar(iniciar),
        .almost_full(af), .full(fl), .almost_empty(ae), .empty(em),
        .pausa(pausa_o[0]), .continuar(cont_o[0]), .error_full(ef_o[0]),
        .error_timeout(et_o[0]), .error_ch(ch_o[0]), .idle(idle_o[0]), .state(st_o[0])
    );

    flow_ctrl_fsm #(.NUM_CH(4), .CH_W(3), .STALL_MAX(0), .CNT_W(5)) u_b (
        .clk(clk), .rst(rst), .enb(enb), .iniciar(iniciar),
        .almost_full(af), .full(fl), .almost_empty(ae), .empty(em),
        .pausa(pausa_o[1]), .continuar(cont_o[1]), .error_full(ef_o[1]),
        .error_timeout(et_o[1]), .error_ch(ch_o[1]), .idle(idle_o[1]), .state(st_o[1])
    );

    task automatic model_step(input int k);
        int nxt;
        int hit;
        int fidx;
        logic [3:0] pz;
        if (!rst) begin
            m_st[k] = 0; m_p[k] = '0; m_c[k] = '0;
            m_ef[k] = 0; m_et[k] = 0; m_ch[k] = 0; m_id[k] = 0;
            for (int i = 0; i < 4; i++) begin
                m_hy[k][i] = 0;
                m_cnt[k][i] = 0;
            end
        end else if (enb) begin
            hit = -1;
            for (int i = 0; i < 4; i++)
                if (smax[k] != 0 && m_cnt[k][i] == smax[k] && hit < 0) hit = i;
            fidx = -1;
            for (int i = 0; i < 5; i++)
                if (fl[i] && fidx < 0) fidx = i;

            case (m_st[k])
                0:       nxt = 1;
                1:       nxt = iniciar ? 2 : 1;
                2, 3:    nxt = (fidx >= 0 || hit >= 0) ? 4 : ((em == 5'h1f) ? 2 : 3);
                default: nxt = iniciar ? 1 : 4;
            endcase

            if (nxt == 4 && m_st[k] != 4) begin
                m_ef[k] = (fidx >= 0);
                m_et[k] = (fidx < 0);
                m_ch[k] = (fidx >= 0) ? fidx : hit;
            end else if (nxt != 4) begin
                m_ef[k] = 0; m_et[k] = 0; m_ch[k] = 0;
            end

            for (int i = 0; i < 4; i++) begin
                if (nxt <= 1)
                    m_hy[k][i] = 0;
                else if (nxt == 3 && af[i] && !ae[i])
                    m_hy[k][i] = 1;
                else if (nxt == 3 && ae[i] && !af[i])
                    m_hy[k][i] = 0;
                pz[i] = (nxt == 4) || (nxt == 3 && (m_hy[k][i] || af[4]));
                if (nxt <= 1 || !pz[i])
                    m_cnt[k][i] = 0;
                else
                    m_cnt[k][i] = (m_cnt[k][i] + 1 > smax[k]) ? smax[k] : m_cnt[k][i] + 1;
            end

            m_p[k]  = pz;
            m_c[k]  = (nxt == 2) ? 4'hf : ((nxt == 3) ? ~pz : 4'h0);
            m_id[k] = (nxt == 2);
            m_st[k] = nxt;
        end
    endtask

    task automatic chk(input string tag, input int k, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s dut%0d: observed %0h expected %0h", tag, k, got, exp);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            chk("state",     k, 8'(st_o[k]),    8'(m_st[k]));
            chk("pausa",     k, 8'(pausa_o[k]), 8'(m_p[k]));
            chk("continuar", k, 8'(cont_o[k]),  8'(m_c[k]));
            chk("err_full",  k, 8'(ef_o[k]),    8'(m_ef[k]));
            chk("err_to",    k, 8'(et_o[k]),    8'(m_et[k]));
            chk("err_ch",    k, 8'(ch_o[k]),    8'(m_ch[k]));
            chk("idle",      k, 8'(idle_o[k]),  8'(m_id[k]));
        end
    endtask

    task automatic cycle(input int n);
        for (int j = 0; j < n; j++) begin
            @(posedge clk);
            model_step(0);
            model_step(1);
            #1;
            check_all();
        end
    endtask

    initial begin
        rst = 1'b0; enb = 1'b1; iniciar = 1'b0;
        af = '0; fl = '0; ae = '0; em = 5'h1f;

        cycle(2);
        chk("reset_state", 0, 8'(st_o[0]), 8'd0);
        rst = 1'b1;
        cycle(1);
        chk("to_init", 0, 8'(st_o[0]), 8'd1);
        iniciar = 1'b1;
        cycle(1);
        chk("to_idle", 0, 8'(st_o[0]), 8'd2);
        chk("idle_cont", 0, 8'(cont_o[0]), 8'hf);
        iniciar = 1'b0;
        em = 5'h1e;
        cycle(1);
        chk("to_active", 0, 8'(st_o[0]), 8'd3);

        // Hysteresis on channel 2
        af = 5'b00100;
        cycle(1);
        af = '0;
        chk("hyst_set", 0, 8'(pausa_o[0]), 8'h4);
        cycle(3);
        chk("hyst_hold", 0, 8'(pausa_o[0]), 8'h4);
        ae = 5'b00100;
        cycle(1);
        ae = '0;
        chk("hyst_clr", 0, 8'(pausa_o[0]), 8'h0);
        chk("hyst_cont", 0, 8'(cont_o[0]), 8'hf);

        // Input FIFO almost_full forces all pauses for one cycle
        af = 5'h10;
        cycle(1);
        af = '0;
        chk("in_af_force", 0, 8'(pausa_o[0]), 8'hf);
        cycle(1);
        chk("in_af_release", 0, 8'(pausa_o[0]), 8'h0);

        // Full error on channels 1 and 3
        fl = 5'b01010;
        cycle(1);
        fl = '0;
        chk("full_state", 0, 8'(st_o[0]), 8'd4);
        chk("full_flag", 0, 8'(ef_o[0]), 8'd1);
        chk("full_ch", 0, 8'(ch_o[0]), 8'd1);
        cycle(3);
        chk("err_sticky", 0, 8'(st_o[0]), 8'd4);
        iniciar = 1'b1;
        cycle(1);
        chk("recover_init", 0, 8'(st_o[0]), 8'd1);
        chk("recover_clr", 0, 8'(ef_o[0]), 8'd0);
        cycle(1);
        iniciar = 1'b0;
        cycle(1);

        // Stall timeout on channel 0
        af = 5'b00001;
        cycle(1);
        af = '0;
        cycle(15);
        chk("to_not_yet", 0, 8'(et_o[0]), 8'd0);
        cycle(1);
        chk("to_flag", 0, 8'(et_o[0]), 8'd1);
        chk("to_ch", 0, 8'(ch_o[0]), 8'd0);
        cycle(100);
        chk("to_disabled_state", 1, 8'(st_o[1]), 8'd3);
        chk("to_disabled_flag", 1, 8'(et_o[1]), 8'd0);

        // Input FIFO full reports index NUM_CH
        rst = 1'b0;
        cycle(1);
        rst = 1'b1;
        iniciar = 1'b1;
        cycle(3);
        iniciar = 1'b0;
        fl = 5'h10;
        cycle(1);
        fl = '0;
        chk("in_full_ch", 0, 8'(ch_o[0]), 8'd4);
        chk("in_full_ch", 1, 8'(ch_o[1]), 8'd4);

        // enb low freezes everything
        iniciar = 1'b1;
        cycle(2);
        iniciar = 1'b0;
        cycle(1);
        enb = 1'b0;
        fl = 5'b00001;
        for (int j = 0; j < 6; j++) begin
            af = af ^ 5'b00010;
            cycle(1);
        end
        chk("enb_hold", 0, 8'(st_o[0]), 8'd3);
        enb = 1'b1;
        cycle(1);
        fl = '0; af = '0;
        chk("enb_err", 0, 8'(st_o[0]), 8'd4);
        chk("enb_ch", 0, 8'(ch_o[0]), 8'd0);

        // Reset mid-ACTIVE with pauses held
        iniciar = 1'b1;
        cycle(2);
        iniciar = 1'b0;
        cycle(1);
        af = 5'b01010;
        cycle(1);
        af = '0;
        chk("pre_rst_pausa", 0, 8'(pausa_o[0]), 8'ha);
        rst = 1'b0;
        cycle(2);
        chk("mid_rst_state", 0, 8'(st_o[0]), 8'd0);
        chk("mid_rst_pausa", 0, 8'(pausa_o[0]), 8'd0);
        rst = 1'b1;

        // Randomized traffic
        for (int j = 0; j < 800; j++) begin
            rst     = ($urandom_range(0, 99) != 0);
            enb     = ($urandom_range(0, 9) != 0);
            iniciar = ($urandom_range(0, 7) == 0);
            af      = 5'($urandom) & 5'($urandom) & 5'($urandom);
            ae      = 5'($urandom) & 5'($urandom);
            fl      = ($urandom_range(0, 39) == 0) ? 5'(1 << $urandom_range(0, 4)) : 5'd0;
            em      = ($urandom_range(0, 3) == 0) ? 5'h1f : 5'($urandom);
            cycle(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
